// File: rtl/cache_pkg.sv
// Shared types and defaults for the cache power-on initialisation sequencer.
package cache_pkg;

  localparam int unsigned DEF_INDEX_WIDTH = 8;
  localparam int unsigned DEF_TAG_WIDTH   = 14;
  localparam int unsigned PERF_WIDTH      = 32;

  // Per-line state word held in the tag/state RAM.
  typedef struct packed {
    logic                     valid;
    logic                     dirty;
    logic [DEF_TAG_WIDTH-1:0] tag;
  } line_state_t;

  localparam line_state_t LINE_STATE_INVALID = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_CALIB,
    S_CLEAR,
    S_DONE
  } init_state_t;

endpackage : cache_pkg

// File: rtl/cache_init_seq.sv
// Power-on cache initialisation: after launch and DDR calibration, writes an
// invalid line-state word to every cache index, then raises cache_ready.
// Loss of calibration aborts or invalidates the sweep and forces a restart.
// Optional macro CACHE_INIT_PERF_EN adds the init_cycles performance counter.
module cache_init_seq
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int unsigned TAG_WIDTH   = DEF_TAG_WIDTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   launch,
  input  logic                   calib_done,
  output logic                   tag_wr_valid,
  input  logic                   tag_wr_ready,
  output logic [INDEX_WIDTH-1:0] tag_wr_addr,
  output logic [TAG_WIDTH+1:0]   tag_wr_data,
  output logic                   cache_ready
`ifdef CACHE_INIT_PERF_EN
  ,
  output logic [PERF_WIDTH-1:0]  init_cycles
`endif
);

  localparam int unsigned DATA_WIDTH = TAG_WIDTH + 2;

  init_state_t            state_q, state_d;
  logic [INDEX_WIDTH-1:0] index_q, index_d;
  logic                   tag_wr_valid_q, tag_wr_valid_d;
  logic [INDEX_WIDTH-1:0] tag_wr_addr_q, tag_wr_addr_d;
  logic [DATA_WIDTH-1:0]  tag_wr_data_q, tag_wr_data_d;
  logic                   cache_ready_q, cache_ready_d;
  logic                   beat_accepted;
  logic                   last_index;

  assign beat_accepted = tag_wr_valid_q & tag_wr_ready;
  assign last_index    = &index_q;

  // Next-state, index and output decode; outputs follow the next state so
  // they leave the flops aligned with the state they belong to.
  always_comb begin
    state_d        = state_q;
    index_d        = index_q;
    tag_wr_valid_d = 1'b0;
    tag_wr_addr_d  = '0;
    tag_wr_data_d  = DATA_WIDTH'(LINE_STATE_INVALID);
    cache_ready_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (launch) begin
          state_d = S_WAIT_CALIB;
        end
      end
      S_WAIT_CALIB: begin
        index_d = '0;
        if (calib_done) begin
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        // Calibration loss wins over a beat accepted in the same cycle.
        if (!calib_done) begin
          state_d = S_WAIT_CALIB;
          index_d = '0;
        end else if (beat_accepted) begin
          if (last_index) begin
            state_d = S_DONE;
            index_d = '0;
          end else begin
            index_d = index_q + INDEX_WIDTH'(1);
          end
        end
      end
      S_DONE: begin
        // DDR contents are considered lost: re-sweep from scratch.
        if (!calib_done) begin
          state_d = S_WAIT_CALIB;
          index_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        index_d = '0;
      end
    endcase

    tag_wr_valid_d = (state_d == S_CLEAR);
    tag_wr_addr_d  = index_d;
    cache_ready_d  = (state_d == S_DONE);
  end

  // State, index and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      index_q        <= '0;
      tag_wr_valid_q <= 1'b0;
      tag_wr_addr_q  <= '0;
      tag_wr_data_q  <= '0;
      cache_ready_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      index_q        <= index_d;
      tag_wr_valid_q <= tag_wr_valid_d;
      tag_wr_addr_q  <= tag_wr_addr_d;
      tag_wr_data_q  <= tag_wr_data_d;
      cache_ready_q  <= cache_ready_d;
    end
  end

  assign tag_wr_valid = tag_wr_valid_q;
  assign tag_wr_addr  = tag_wr_addr_q;
  assign tag_wr_data  = tag_wr_data_q;
  assign cache_ready  = cache_ready_q;

`ifdef CACHE_INIT_PERF_EN
  logic [PERF_WIDTH-1:0] init_cycles_q, init_cycles_d;
  logic                  perf_busy;

  assign perf_busy = (state_q == S_WAIT_CALIB) || (state_q == S_CLEAR);

  // Saturating count of cycles spent waiting for calibration or sweeping.
  always_comb begin
    init_cycles_d = init_cycles_q;
    if (perf_busy && !(&init_cycles_q)) begin
      init_cycles_d = init_cycles_q + PERF_WIDTH'(1);
    end
  end

  // Performance counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      init_cycles_q <= '0;
    end else begin
      init_cycles_q <= init_cycles_d;
    end
  end

  assign init_cycles = init_cycles_q;
`endif

endmodule : cache_init_seq

// File: tb/tb_cache_init_seq.sv
// Directed bench for cache_init_seq with INDEX_WIDTH=2 (four indices).
module tb_cache_init_seq;

  localparam int unsigned IW = 2;
  localparam int unsigned TW = 14;

  logic          clk;
  logic          rstn;
  logic          launch;
  logic          calib_done;
  logic          tag_wr_valid;
  logic          tag_wr_ready;
  logic [IW-1:0] tag_wr_addr;
  logic [TW+1:0] tag_wr_data;
  logic          cache_ready;
`ifdef CACHE_INIT_PERF_EN
  logic [31:0]   init_cycles;
`endif

  int errors = 0;
  int checks = 0;

  cache_init_seq #(
    .INDEX_WIDTH(IW),
    .TAG_WIDTH  (TW)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .launch      (launch),
    .calib_done  (calib_done),
    .tag_wr_valid(tag_wr_valid),
    .tag_wr_ready(tag_wr_ready),
    .tag_wr_addr (tag_wr_addr),
    .tag_wr_data (tag_wr_data),
    .cache_ready (cache_ready)
`ifdef CACHE_INIT_PERF_EN
    ,
    .init_cycles (init_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Input drive during period p (the interval ending at edge p+1).
  function automatic logic in_calib(input int id, input int p);
    case (id)
      3:       return (p >= 10);
      4:       return !(p >= 3 && p <= 5);
      5:       return (p != 7);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic in_ready(input int id, input int p);
    if (id == 2) return !(p >= 4 && p <= 6);
    return 1'b1;
  endfunction

  function automatic logic in_rstn(input int id, input int p);
    if (id == 6) return (p != 4);
    return 1'b1;
  endfunction

  function automatic logic in_launch(input int id, input int p);
    if (id == 1) return (p < 3);
    return 1'b1;
  endfunction

  // Expected presented address at cycle c, or -1 when no write is valid.
  function automatic int exp_addr(input int id, input int c);
    case (id)
      1: if (c >= 2 && c <= 5) return c - 2;
      2: begin
        if (c == 2) return 0;
        if (c == 3) return 1;
        if (c >= 4 && c <= 7) return 2;
        if (c == 8) return 3;
      end
      3: if (c >= 11 && c <= 14) return c - 11;
      4: begin
        if (c == 2) return 0;
        if (c == 3) return 1;
        if (c >= 7 && c <= 10) return c - 7;
      end
      5: begin
        if (c >= 2 && c <= 5) return c - 2;
        if (c >= 9 && c <= 12) return c - 9;
      end
      6: begin
        if (c >= 2 && c <= 4) return c - 2;
        if (c >= 7 && c <= 10) return c - 7;
      end
      default: return -1;
    endcase
    return -1;
  endfunction

  function automatic logic exp_rdy(input int id, input int c);
    case (id)
      1:       return (c >= 6);
      2:       return (c >= 9);
      3:       return (c >= 15);
      4:       return (c >= 11);
      5:       return (c == 6 || c == 7 || c >= 13);
      6:       return (c >= 11);
      default: return 1'b0;
    endcase
  endfunction

  task automatic do_reset(input int id);
    rstn         = 1'b0;
    launch       = 1'b0;
    calib_done   = 1'b0;
    tag_wr_ready = 1'b1;
    step();
    step();
    check($sformatf("s%0d_rst_valid", id), 32'(tag_wr_valid), 32'd0);
    check($sformatf("s%0d_rst_addr", id),  32'(tag_wr_addr),  32'd0);
    check($sformatf("s%0d_rst_data", id),  32'(tag_wr_data),  32'd0);
    check($sformatf("s%0d_rst_rdy", id),   32'(cache_ready),  32'd0);
`ifdef CACHE_INIT_PERF_EN
    check($sformatf("s%0d_rst_perf", id),  init_cycles,       32'd0);
`endif
  endtask

  task automatic run_scen(input int id, input int ncyc);
    int    ea;
    string tag;
    do_reset(id);
    for (int c = 1; c <= ncyc; c++) begin
      rstn         = in_rstn(id, c - 1);
      launch       = in_launch(id, c - 1);
      calib_done   = in_calib(id, c - 1);
      tag_wr_ready = in_ready(id, c - 1);
      step();
      ea  = exp_addr(id, c);
      tag = $sformatf("s%0d_c%0d", id, c);
      check({tag, "_valid"}, 32'(tag_wr_valid), 32'(ea >= 0));
      check({tag, "_addr"},  32'(tag_wr_addr),  (ea >= 0) ? 32'(ea) : 32'd0);
      check({tag, "_rdy"},   32'(cache_ready),  32'(exp_rdy(id, c)));
      check({tag, "_data"},  32'(tag_wr_data),  32'd0);
`ifdef CACHE_INIT_PERF_EN
      if (id == 1 && c >= 6) check({tag, "_perf"}, init_cycles, 32'd5);
`endif
    end
  endtask

  initial begin
    rstn         = 1'b0;
    launch       = 1'b0;
    calib_done   = 1'b0;
    tag_wr_ready = 1'b1;
    run_scen(1, 9);   // clean sweep, launch dropped afterwards
    run_scen(2, 10);  // back-pressure while addr=2
    run_scen(3, 16);  // late calibration
    run_scen(4, 12);  // calibration loss mid-sweep
    run_scen(5, 14);  // calibration glitch in done state
    run_scen(6, 12);  // reset mid-sweep with launch held
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_cache_init_seq
